// File: rtl/rally_controller.sv
// rally_controller: game-flow FSM that serves the ball, scores wall hits, ramps speed and counts lives.
module rally_controller #(
   parameter int SERVE_TICKS    = 60,
   parameter int MISS_TICKS     = 30,
   parameter int LIVES          = 3,
   parameter int SPEED_INIT     = 1,
   parameter int SPEED_MAX      = 8,
   parameter int HITS_PER_LEVEL = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick,
   input  logic       start,
   input  logic       hit,
   input  logic       oob,
   output logic       ball_rst_n,
   output logic [4:0] speed,
   output logic [7:0] score,
   output logic [7:0] best,
   output logic [1:0] lives,
   output logic       game_over,
   output logic [2:0] state
);
   typedef enum logic [2:0] {IDLE = 3'd0, SERVE = 3'd1, PLAY = 3'd2, MISS = 3'd3, OVER = 3'd4} state_t;
   state_t st, st_n;
   logic [7:0] timer, timer_n, level, level_n, score_n, best_n;
   logic [4:0] speed_n;
   logic [1:0] lives_n;
   logic start_prev, hit_prev, start_rise, hit_rise;
   assign start_rise = start & ~start_prev;
   assign hit_rise   = hit & ~hit_prev;
   assign state      = st;
   always_comb begin
      st_n    = st;
      timer_n = timer;
      level_n = level;
      score_n = score;
      best_n  = best;
      speed_n = speed;
      lives_n = lives;
      case (st)
         IDLE, OVER: if (start_rise) begin
            st_n    = SERVE;
            timer_n = 8'(SERVE_TICKS);
            score_n = 8'd0;
            lives_n = 2'(LIVES);
            speed_n = 5'(SPEED_INIT);
            level_n = 8'd0;
         end
         SERVE: if (tick) begin
            timer_n = timer - 8'd1;
            st_n    = timer == 8'd1 ? PLAY : SERVE;
         end
         PLAY: if (oob) begin
            st_n    = MISS;
            timer_n = 8'(MISS_TICKS);
            lives_n = lives == 2'd0 ? 2'd0 : lives - 2'd1;
         end else if (hit_rise) begin
            score_n = score == 8'hff ? score : score + 8'd1;
            // level counter wraps on each speed step
            level_n = level + 8'd1 == 8'(HITS_PER_LEVEL) ? 8'd0 : level + 8'd1;
            speed_n = level + 8'd1 == 8'(HITS_PER_LEVEL) && speed < 5'(SPEED_MAX) ? speed + 5'd1 : speed;
         end
         MISS: if (tick) begin
            timer_n = timer - 8'd1;
            if (timer == 8'd1) begin
               st_n    = lives == 2'd0 ? OVER : SERVE;
               timer_n = lives == 2'd0 ? 8'd0 : 8'(SERVE_TICKS);
               best_n  = lives == 2'd0 && score > best ? score : best;
            end
         end
         default: st_n = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (!reset) begin
         st         <= IDLE;
         timer      <= 8'd0;
         level      <= 8'd0;
         score      <= 8'd0;
         best       <= 8'd0;
         speed      <= 5'(SPEED_INIT);
         lives      <= 2'(LIVES);
         ball_rst_n <= 1'b0;
         game_over  <= 1'b0;
         start_prev <= 1'b0;
         hit_prev   <= 1'b0;
      end else begin
         st         <= st_n;
         timer      <= timer_n;
         level      <= level_n;
         score      <= score_n;
         best       <= best_n;
         speed      <= speed_n;
         lives      <= lives_n;
         ball_rst_n <= st_n == PLAY;
         game_over  <= st_n == OVER;
         start_prev <= start;
         hit_prev   <= hit;
      end
   end
endmodule

// File: tb/tb_rally_controller.sv
// tb_rally_controller: directed game scenarios plus random play, checked against a game-rule model.
module tb_rally_controller;
   localparam int ST = 3, MT = 2, LV = 2, SI = 1, SM = 3, HPL = 2;
   logic clk = 1'b0, reset = 1'b0, tick = 1'b0, start = 1'b0, hit = 1'b0, oob = 1'b0;
   logic ball_rst_n, game_over;
   logic [4:0] speed;
   logic [7:0] score, best;
   logic [1:0] lives;
   logic [2:0] state;
   int n_cmp = 0, n_err = 0;
   int m_st = 0, m_left = 0, m_hits = 0, m_best = 0, m_lives = LV;
   bit m_sp = 0, m_hp = 0;
   rally_controller #(.SERVE_TICKS(ST), .MISS_TICKS(MT), .LIVES(LV), .SPEED_INIT(SI),
                      .SPEED_MAX(SM), .HITS_PER_LEVEL(HPL)) dut (
      .clk(clk), .reset(reset), .tick(tick), .start(start), .hit(hit), .oob(oob),
      .ball_rst_n(ball_rst_n), .speed(speed), .score(score), .best(best), .lives(lives),
      .game_over(game_over), .state(state));
   always #5 clk = ~clk;
   function automatic int m_score();
      return m_hits > 255 ? 255 : m_hits;
   endfunction
   function automatic int m_speed();
      return SI + m_hits / HPL > SM ? SM : SI + m_hits / HPL;
   endfunction
   task automatic check(input string tag, input int obs, input int exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask
   task automatic step(input bit r, input bit tk, input bit s, input bit h, input bit o);
      bit sr, hr;
      reset = r; tick = tk; start = s; hit = h; oob = o;
      @(posedge clk);
      sr = s && !m_sp;
      hr = h && !m_hp;
      if (!r) begin
         m_st = 0; m_left = 0; m_hits = 0; m_best = 0; m_lives = LV; m_sp = 0; m_hp = 0;
      end else begin
         m_sp = s; m_hp = h;
         case (m_st)
            0, 4: if (sr) begin m_st = 1; m_left = ST; m_hits = 0; m_lives = LV; end
            1: if (tk) begin m_left--; if (m_left == 0) m_st = 2; end
            2: if (o) begin m_st = 3; m_left = MT; m_lives = m_lives > 0 ? m_lives - 1 : 0; end
               else if (hr) m_hits++;
            default: if (tk) begin
               m_left--;
               if (m_left == 0) begin
                  if (m_lives == 0) begin m_st = 4; m_best = m_score() > m_best ? m_score() : m_best; end
                  else begin m_st = 1; m_left = ST; end
               end
            end
         endcase
      end
      #1;
      check("state", state, m_st);
      check("ball_rst_n", ball_rst_n, m_st == 2);
      check("game_over", game_over, m_st == 4);
      check("speed", speed, m_speed());
      check("score", score, m_score());
      check("best", best, m_best);
      check("lives", lives, m_lives);
   endtask
   initial begin
      repeat (3) step(0, 0, 0, 0, 0);
      check("rst_state", state, 0);
      check("rst_speed", speed, 1);
      step(1, 0, 1, 0, 0);
      check("start_serve", state, 1);
      repeat (2) step(1, 1, 0, 0, 0);
      check("serve_hold", ball_rst_n, 0);
      step(1, 1, 0, 0, 0);
      check("serve_play", state, 2);
      check("serve_release", ball_rst_n, 1);
      for (int i = 0; i < 5; i++) begin
         step(1, 0, 0, 1, 0);
         step(1, 0, 0, 0, 0);
         if (i == 1) check("speed_lvl1", speed, 2);
      end
      check("five_hits", score, 5);
      check("speed_sat", speed, 3);
      repeat (10) step(1, 0, 0, 1, 0);
      step(1, 0, 0, 0, 0);
      check("held_hit", score, 6);
      step(1, 0, 0, 1, 1);
      check("oob_miss", state, 3);
      check("oob_lives", lives, 1);
      check("oob_noscore", score, 6);
      step(1, 1, 0, 0, 0);
      step(1, 1, 0, 0, 0);
      check("miss_serve", state, 1);
      check("miss_keep_speed", speed, 3);
      repeat (3) step(1, 1, 0, 0, 0);
      step(1, 0, 0, 1, 0);
      step(1, 0, 1, 0, 1);
      check("last_life", lives, 0);
      repeat (2) step(1, 1, 1, 0, 0);
      check("over", state, 4);
      check("over_best", best, 7);
      repeat (3) step(1, 0, 1, 0, 0);
      check("held_start", state, 4);
      step(1, 0, 0, 0, 0);
      step(1, 0, 1, 0, 0);
      check("restart", state, 1);
      check("restart_score", score, 0);
      check("restart_best", best, 7);
      repeat (3) step(1, 1, 0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         step(1, 0, 0, 1, 0);
         step(1, 0, 0, 0, 0);
      end
      step(0, 0, 0, 0, 0);
      check("midgame_rst", state, 0);
      check("midgame_best", best, 0);
      step(1, 0, 1, 0, 0);
      repeat (50) step(1, 0, 0, 0, 0);
      check("frozen", state, 1);
      repeat (2) step(1, 1, 0, 0, 0);
      check("resume_serve", state, 1);
      step(1, 1, 0, 0, 0);
      check("resume_play", state, 2);
      for (int i = 0; i < 3000; i++)
         step($urandom_range(199) != 0, $urandom_range(2) == 0, $urandom_range(7) == 0,
              $urandom_range(2) == 0, $urandom_range(9) == 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
